manchester_transmitter: RTL and testbench

Serializes a stream of bytes into a Manchester-encoded frame for the single-wire link whose receive side is the edge-detect / state-machine / data-multiplex chain. Frame format: a fixed 8-bit preamble, then 1 to MAX_BYTES data bytes, MSB first, then an idle gap. The receive path starts a transmission on the first rising edge and addresses bytes 0..15. Upstream logic feeds bytes through a valid/ready holding register.

---
 rtl/manchester_transmitter_if.sv | 20 ++
 rtl/manchester_transmitter.sv | 147 ++++++++++++++
 tb/tb_manchester_transmitter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_transmitter_if.sv
// Byte feed into the Manchester transmitter: upstream offers a byte with
// data_valid and the transmitter accepts it into its holding register when
// data_ready is high on the same clock edge.
interface manchester_transmitter_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/manchester_transmitter.sv
// Manchester transmitter: frames a byte stream as preamble + 1..MAX_BYTES data
// bytes (MSB first) followed by a forced-low gap. A '1' is sent low-then-high,
// a '0' high-then-low, so the 0xAA preamble produces its first rising edge at
// mid-bit of its first bit, which is what the receiver uses to start a frame.
module manchester_transmitter #(
   parameter int         HALF_BIT_CYCLES = 4,
   parameter logic [7:0] PREAMBLE        = 8'hAA,
   parameter int         MAX_BYTES       = 16,
   parameter int         GAP_BITS        = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   manchester_transmitter_if.slave        feed,
   output logic                           manchester_out,
   output logic                           frame_active,
   output logic [4:0]                     bytes_sent
);

   localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_BIT_CYCLES;
   localparam int HW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [4:0]    MAX_COUNT = 5'(MAX_BYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_GAP
   } state_t;

   state_t          state;
   logic [7:0]      holding;
   logic            holding_full;
   logic [7:0]      shift;
   logic [HW-1:0]   half_cnt;
   logic            half_sel;
   logic [2:0]      bit_idx;
   logic [GW-1:0]   gap_cnt;

   logic            transfer;
   logic            bit_end;
   logic [4:0]      next_count;

   // The holding register accepts a byte only while empty and never in reset,
   // so an upstream transfer can never collide with the FSM emptying it.
   assign feed.data_ready = !holding_full && !reset;
   assign transfer        = feed.data_valid && feed.data_ready;
   assign bit_end         = (half_cnt == HALF_LAST) && half_sel;
   assign next_count      = (bytes_sent == MAX_COUNT) ? bytes_sent : bytes_sent + 5'd1;

   // Frame sequencer: holding register, bit/half-bit timing, gap timer and the
   // registered line outputs all advance together on each clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         holding        <= '0;
         holding_full   <= 1'b0;
         shift          <= '0;
         half_cnt       <= '0;
         half_sel       <= 1'b0;
         bit_idx        <= '0;
         gap_cnt        <= '0;
         bytes_sent     <= '0;
         manchester_out <= 1'b0;
         frame_active   <= 1'b0;
      end else begin
         if (transfer) begin
            holding      <= feed.data_in;
            holding_full <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               manchester_out <= 1'b0;
               frame_active   <= 1'b0;
               if (holding_full) begin
                  shift      <= PREAMBLE;
                  bytes_sent <= '0;
                  half_cnt   <= '0;
                  half_sel   <= 1'b0;
                  bit_idx    <= 3'd7;
                  state      <= S_PREAMBLE;
               end
            end

            S_PREAMBLE, S_DATA: begin
               manchester_out <= shift[7] ~^ half_sel;
               frame_active   <= 1'b1;
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  half_sel <= ~half_sel;
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
               if (bit_end) begin
                  if (bit_idx == 3'd0) begin
                     bit_idx <= 3'd7;
                     if (state == S_DATA) begin
                        bytes_sent <= next_count;
                     end
                     if (holding_full && (state == S_PREAMBLE || next_count < MAX_COUNT)) begin
                        shift        <= holding;
                        holding_full <= 1'b0;
                        state        <= S_DATA;
                     end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                     end
                  end else begin
                     bit_idx <= bit_idx - 3'd1;
                     shift   <= {shift[6:0], 1'b0};
                  end
               end
            end

            S_GAP: begin
               manchester_out <= 1'b0;
               frame_active   <= 1'b0;
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  if (holding_full) begin
                     shift      <= PREAMBLE;
                     bytes_sent <= '0;
                     half_cnt   <= '0;
                     half_sel   <= 1'b0;
                     bit_idx    <= 3'd7;
                     state      <= S_PREAMBLE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               manchester_out <= 1'b0;
               frame_active   <= 1'b0;
               state          <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_manchester_transmitter.sv
// Self-checking bench for manchester_transmitter. Expected frames (preamble
// plus data bytes, byte count, gap expectation) are queued as stimulus is
// issued; a monitor decodes the line every clock and checks against them.
module tb_manchester_transmitter;

   localparam int HALF    = 2;
   localparam int BIT_CYC = 2 * HALF;
   localparam int GAP_LEN = 4 * 2 * HALF;

   typedef struct packed {
      int n;
      bit exact_gap;
   } frame_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       manchester_out;
   logic       frame_active;
   logic [4:0] bytes_sent;

   manchester_transmitter_if feed();

   manchester_transmitter #(
      .HALF_BIT_CYCLES (HALF),
      .PREAMBLE        (8'hAA),
      .MAX_BYTES       (16),
      .GAP_BITS        (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .feed           (feed),
      .manchester_out (manchester_out),
      .frame_active   (frame_active),
      .bytes_sent     (bytes_sent)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_bytes[$];
   frame_t     exp_frames[$];
   int         frames_done = 0;
   bit         mon_en      = 1'b0;
   logic [7:0] rx_mem [0:15];

   bit                 prev_active;
   bit                 have_prev;
   bit                 idle_high;
   int                 idle_cnt;
   int                 active_cnt;
   int                 sym_cnt;
   int                 bit_cnt;
   int                 byte_idx;
   logic [BIT_CYC-1:0] sym;
   logic [7:0]         shreg;
   frame_t             cur;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name, input int actual);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected nothing", name, actual);
   endtask

   task automatic pushFrame(input logic [7:0] first, input int n, input bit exact_gap);
      exp_bytes.push_back(8'hAA);
      for (int i = 0; i < n; i++) exp_bytes.push_back(first + 8'(i));
      exp_frames.push_back('{n, exact_gap});
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      int cyc = 0;
      feed.data_in    = b;
      feed.data_valid = 1'b1;
      while (!feed.data_ready && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
      if (!feed.data_ready) begin
         failNow("ready_timeout", b);
         feed.data_valid = 1'b0;
      end else begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic waitFrames(input int target, input int budget);
      int cyc = 0;
      while (frames_done < target && cyc < budget) begin
         @(posedge clock);
         cyc++;
      end
      if (frames_done < target) failNow("frame_timeout", frames_done);
      @(negedge clock);
   endtask

   task automatic waitActive(input int budget);
      int cyc = 0;
      while (!frame_active && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      if (!frame_active) failNow("active_timeout", cyc);
   endtask

   task automatic waitBytesSent(input int value, input int budget);
      int cyc = 0;
      while (int'(bytes_sent) != value && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      if (int'(bytes_sent) != value) failNow("bytes_sent_timeout", bytes_sent);
   endtask

   // Monitor: decodes each bit period of the line while frame_active, checks
   // bytes, frame length, byte count and the low gap between frames.
   always @(negedge clock) begin
      if (!mon_en) begin
         prev_active = 1'b0;
         have_prev   = 1'b0;
         idle_cnt    = 0;
         idle_high   = 1'b0;
         sym_cnt     = 0;
         bit_cnt     = 0;
      end else begin
         if (frame_active) begin
            if (!prev_active) begin
               if (exp_frames.size() == 0) begin
                  failNow("unexpected_frame", frames_done);
               end else if (have_prev) begin
                  checkOutput("gap_low", idle_high, 0);
                  if (exp_frames[0].exact_gap) checkOutput("gap_exact", idle_cnt, GAP_LEN);
                  else checkOutput($sformatf("gap_min(%0d)", idle_cnt), int'(idle_cnt >= GAP_LEN), 1);
               end
               active_cnt = 0;
               sym_cnt    = 0;
               bit_cnt    = 0;
               byte_idx   = 0;
            end
            active_cnt++;
            sym = {sym[BIT_CYC-2:0], manchester_out};
            sym_cnt++;
            if (sym_cnt == BIT_CYC) begin
               sym_cnt = 0;
               checkOutput("symbol_shape", sym, {{HALF{~sym[0]}}, {HALF{sym[0]}}});
               shreg = {shreg[6:0], sym[0]};
               bit_cnt++;
               if (bit_cnt == 8) begin
                  bit_cnt = 0;
                  if (exp_bytes.size() == 0) failNow("unexpected_byte", shreg);
                  else checkOutput($sformatf("byte%0d", byte_idx), shreg, exp_bytes.pop_front());
                  if (byte_idx > 0 && byte_idx <= 16) rx_mem[byte_idx-1] = shreg;
                  byte_idx++;
               end
            end
         end else begin
            if (prev_active) begin
               if (exp_frames.size() == 0) begin
                  failNow("unexpected_frame_end", active_cnt);
               end else begin
                  cur = exp_frames.pop_front();
                  checkOutput("frame_len", active_cnt, (1 + cur.n) * 16 * HALF);
                  checkOutput("bytes_sent", bytes_sent, cur.n);
               end
               frames_done++;
               have_prev = 1'b1;
               idle_cnt  = 0;
               idle_high = 1'b0;
            end
            idle_cnt++;
            if (manchester_out) idle_high = 1'b1;
         end
         prev_active = frame_active;
      end
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      int toggles;
      reset           = 1'b1;
      feed.data_valid = 1'b0;
      feed.data_in    = 8'h00;
      repeat (3) @(negedge clock);
      checkOutput("rst_ready", feed.data_ready, 0);
      checkOutput("rst_line", manchester_out, 0);
      checkOutput("rst_active", frame_active, 0);
      checkOutput("rst_bytes", bytes_sent, 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("ready_after_rst", feed.data_ready, 1);
      mon_en = 1'b1;

      $display("[TB] single byte");
      pushFrame(8'hA5, 1, 1'b0);
      applyStimulus(8'hA5);
      feed.data_valid = 1'b0;
      checkOutput("latency_t0", frame_active, 0);
      @(negedge clock);
      checkOutput("latency_t1", frame_active, 0);
      @(negedge clock);
      checkOutput("latency_t2", frame_active, 1);
      checkOutput("ready_while_full", feed.data_ready, 0);
      waitFrames(1, 300);

      $display("[TB] streaming");
      exp_bytes.push_back(8'hAA);
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h3C);
      exp_frames.push_back('{3, 1'b0});
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      applyStimulus(8'h3C);
      feed.data_valid = 1'b0;
      waitFrames(2, 400);

      $display("[TB] frame limit");
      pushFrame(8'h40, 16, 1'b0);
      pushFrame(8'h50, 4, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus(8'h40 + 8'(i));
      feed.data_valid = 1'b0;
      waitFrames(4, 2000);

      $display("[TB] late byte");
      pushFrame(8'h5A, 1, 1'b0);
      pushFrame(8'hC3, 1, 1'b1);
      applyStimulus(8'h5A);
      feed.data_valid = 1'b0;
      waitActive(100);
      waitBytesSent(1, 200);
      applyStimulus(8'hC3);
      feed.data_valid = 1'b0;
      waitFrames(6, 400);

      $display("[TB] reset mid-frame");
      mon_en = 1'b0;
      applyStimulus(8'h96);
      feed.data_valid = 1'b0;
      waitActive(100);
      applyStimulus(8'h11);
      feed.data_valid = 1'b0;
      repeat (17) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midrst_line", manchester_out, 0);
      checkOutput("midrst_active", frame_active, 0);
      checkOutput("midrst_ready", feed.data_ready, 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midrst_ready_after", feed.data_ready, 1);
      toggles = 0;
      repeat (60) begin
         @(negedge clock);
         if (manchester_out || frame_active) toggles++;
      end
      checkOutput("quiet_after_rst", toggles, 0);

      $display("[TB] loopback");
      mon_en = 1'b1;
      exp_bytes.push_back(8'hAA);
      exp_bytes.push_back(8'h81);
      exp_bytes.push_back(8'h7E);
      exp_frames.push_back('{2, 1'b0});
      applyStimulus(8'h81);
      applyStimulus(8'h7E);
      feed.data_valid = 1'b0;
      waitFrames(7, 400);
      checkOutput("rx_addr0", rx_mem[0], 8'h81);
      checkOutput("rx_addr1", rx_mem[1], 8'h7E);
      repeat (GAP_LEN + 4) @(negedge clock);
      checkOutput("exp_bytes_left", exp_bytes.size(), 0);
      checkOutput("exp_frames_left", exp_frames.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
